spi_secondary: RTL and testbench

Clock-synchronous SPI secondary (responder): the far end of the link driven by `spi_core`. It oversamples the primary's `sclk`/`cs`/`mosi` in the system clock domain, shifts a DWIDTH-bit word out on `miso` while shifting one in from `mosi`, and presents the received word to local logic with a valid/acknowledge handshake. It is used as synthesizable loopback and test target for the SPI primary and as a peripheral front end.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync.sv | 27 ++
 rtl/spi_secondary.sv | 171 +++++++++++++++++
 tb/tb_spi_secondary.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: link state encoding, default word width and sizing helpers.
package spi_pkg;

    localparam int unsigned SPI_DWIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for an asynchronous input plus rise/fall detection
// against a third registered copy.
module spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] pipe;

    // Cleared on reset so a line held low through reset release shows no edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe <= 3'b000;
        end else begin
            pipe <= {pipe[1:0], raw};
        end
    end

    assign level = pipe[1];
    assign rise  = pipe[1] & ~pipe[2];
    assign fall  = ~pipe[1] & pipe[2];

endmodule

// File: rtl/spi_secondary.sv
// SPI secondary: oversamples sclk/cs/mosi, shifts a word MSB-first in both
// directions and hands received words to local logic with valid/ack.
module spi_secondary
    import spi_pkg::*;
#(
    parameter int unsigned DWIDTH = SPI_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              rx_valid,
    output logic              done,
    output logic              busy,
    output logic              overrun,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso
);

    localparam int unsigned      CNT_W    = cnt_width(DWIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DWIDTH - 1);

    spi_state_e        state;
    spi_state_e        state_next;
    logic [DWIDTH-1:0] tx_hold;
    logic [DWIDTH-1:0] tx_hold_next;
    logic [DWIDTH-1:0] shreg;
    logic [DWIDTH-1:0] shreg_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [DWIDTH-1:0] dout_next;
    logic              rx_valid_next;
    logic              done_next;
    logic              busy_next;
    logic              overrun_next;
    logic              miso_next;

    logic sclk_level;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic mosi_level;
    logic mosi_rise;
    logic mosi_fall;
    logic [3:0] sync_unused;

    spi_sync u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .raw   (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync u_sync_cs (
        .clk   (clk),
        .rst   (rst),
        .raw   (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync u_sync_mosi (
        .clk   (clk),
        .rst   (rst),
        .raw   (mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    // Only the edges of sclk/cs and the level of mosi drive the link.
    assign sync_unused = {sclk_level, cs_level, mosi_rise, mosi_fall};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tx_hold  <= '0;
            shreg    <= '0;
            cnt      <= '0;
            dout     <= '0;
            rx_valid <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            miso     <= 1'b0;
        end else begin
            state    <= state_next;
            tx_hold  <= tx_hold_next;
            shreg    <= shreg_next;
            cnt      <= cnt_next;
            dout     <= dout_next;
            rx_valid <= rx_valid_next;
            done     <= done_next;
            busy     <= busy_next;
            overrun  <= overrun_next;
            miso     <= miso_next;
        end
    end

    // Next-state and datapath; word loads always take the pre-write tx_hold.
    always_comb begin
        state_next    = state;
        tx_hold_next  = wr ? din : tx_hold;
        shreg_next    = shreg;
        cnt_next      = cnt;
        dout_next     = dout;
        rx_valid_next = rx_valid;
        done_next     = 1'b0;
        overrun_next  = overrun;
        miso_next     = miso;

        if (rd) begin
            rx_valid_next = 1'b0;
            overrun_next  = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_next  = '0;
                miso_next = 1'b0;
                if (cs_fall) begin
                    state_next = SHIFT;
                    shreg_next = tx_hold;
                    miso_next  = tx_hold[DWIDTH-1];
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    // Deselect beats any sclk edge seen in the same cycle.
                    state_next = IDLE;
                    cnt_next   = '0;
                    miso_next  = 1'b0;
                end else if (sclk_rise) begin
                    shreg_next = {shreg[DWIDTH-2:0], mosi_level};
                    if (cnt == LAST_BIT) begin
                        dout_next     = {shreg[DWIDTH-2:0], mosi_level};
                        rx_valid_next = 1'b1;
                        done_next     = 1'b1;
                        cnt_next      = '0;
                        shreg_next    = tx_hold;
                        if (rx_valid && !rd) begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    miso_next = shreg[DWIDTH-1];
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == SHIFT);
    end

endmodule

// File: tb/tb_spi_secondary.sv
// Bench for spi_secondary: acts as SPI primary, keeps a word-level reference
// model of the secondary and compares every output on every cycle.
module tb_spi_secondary;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rx_valid;
    logic       done;
    logic       busy;
    logic       overrun;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    int checks     = 0;
    int failures   = 0;
    int done_cnt   = 0;
    bit chk_en     = 1'b0;
    bit rand_local = 1'b0;

    always #5 clk = ~clk;

    spi_secondary #(.DWIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd),
        .wr       (wr),
        .din      (din),
        .dout     (dout),
        .rx_valid (rx_valid),
        .done     (done),
        .busy     (busy),
        .overrun  (overrun),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the secondary sees pin values two cycles late, then
    // acts on whole-word rules (bit position, current tx word, flags).
    typedef struct packed {
        logic cs;
        logic sclk;
        logic mosi;
    } pins_t;

    pins_t      hist[$];
    logic       m_sel;
    int         m_nbits;
    int         m_rxacc;
    logic [7:0] m_txword;
    logic [7:0] m_hold;
    logic [7:0] m_dout;
    logic       m_rxv;
    logic       m_done;
    logic       m_ovr;
    logic       m_miso;

    always @(posedge clk) begin : model
        pins_t      cur;
        pins_t      prev;
        logic       rs, fs, cr, cf, rxv_old;
        logic [7:0] hold_old;
        int         sz;
        hist.push_back(rst === 1'b1 ? pins_t'({cs, sclk, mosi}) : pins_t'(3'b000));
        if (hist.size() > 4) void'(hist.pop_front());
        sz = hist.size();
        cur  = (sz >= 4) ? hist[sz-3] : pins_t'(3'b000);
        prev = (sz >= 4) ? hist[sz-4] : pins_t'(3'b000);
        if (rst !== 1'b1) begin
            m_sel = 0; m_nbits = 0; m_rxacc = 0; m_txword = 0; m_hold = 0;
            m_dout = 0; m_rxv = 0; m_done = 0; m_ovr = 0; m_miso = 0;
        end else begin
            rs = cur.sclk & ~prev.sclk;
            fs = ~cur.sclk & prev.sclk;
            cr = cur.cs & ~prev.cs;
            cf = ~cur.cs & prev.cs;
            hold_old = m_hold;
            rxv_old  = m_rxv;
            m_done   = 0;
            if (rd) begin m_rxv = 0; m_ovr = 0; end
            if (!m_sel) begin
                m_miso = 0;
                if (cf) begin
                    m_sel = 1; m_nbits = 0; m_rxacc = 0;
                    m_txword = hold_old; m_miso = hold_old[7];
                end
            end else if (cr) begin
                m_sel = 0; m_miso = 0;
            end else if (rs) begin
                m_rxacc = m_rxacc * 2 + int'(cur.mosi);
                m_nbits++;
                if (m_nbits == 8) begin
                    m_dout = 8'(m_rxacc);
                    if (rxv_old && !rd) m_ovr = 1;
                    m_rxv = 1; m_done = 1;
                    m_nbits = 0; m_rxacc = 0; m_txword = hold_old;
                end
            end else if (fs) begin
                m_miso = m_txword[7 - m_nbits];
            end
            if (wr) m_hold = din;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dout", dout, m_dout);
            check("rx_valid", 8'(rx_valid), 8'(m_rxv));
            check("done", 8'(done), 8'(m_done));
            check("busy", 8'(busy), 8'(m_sel));
            check("overrun", 8'(overrun), 8'(m_ovr));
            check("miso", 8'(miso), 8'(m_miso));
            if (done === 1'b1) done_cnt++;
        end
    end

    // Random local-side traffic while the random phase runs.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_local) begin
                rd  = ($urandom_range(0, 7) == 0);
                wr  = ($urandom_range(0, 7) == 0);
                din = 8'($urandom);
            end
        end
    end

    task automatic wait_phase();
        repeat ($urandom_range(4, 7)) @(negedge clk);
    endtask

    task automatic cs_down();
        cs = 1'b0;
        wait_phase();
    endtask

    task automatic cs_up();
        wait_phase();
        cs = 1'b1;
        wait_phase();
    endtask

    // Primary side: drive nbits of mo, capture miso just before each rising sclk.
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit rd_last,
                        output logic [7:0] mi);
        int hp;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            wait_phase();
            mi[7-i] = miso;
            sclk = 1'b1;
            hp = $urandom_range(4, 7);
            for (int j = 1; j <= hp; j++) begin
                @(negedge clk);
                if (rd_last && i == nbits - 1) begin
                    if (j == 2) rd = 1'b1;
                    else if (j == 3) rd = 1'b0;
                end
            end
            sclk = 1'b0;
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] mi;
        int d0;
        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        rd = 1'b0; wr = 1'b0; din = 8'h00;

        // Reset with random pin activity.
        repeat (2) begin
            @(negedge clk);
            chk_en = 1'b1;
            sclk = 1'($urandom); mosi = 1'($urandom); cs = 1'($urandom);
            rd = 1'($urandom); wr = 1'($urandom); din = 8'($urandom);
        end
        @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_miso", 8'(miso), 8'h00);
        check("rst_flags", {4'h0, done, rx_valid, busy, overrun}, 8'h00);
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; rd = 1'b0; wr = 1'b0;
        repeat (8) @(negedge clk);

        // Single word.
        wr = 1'b1; din = 8'hA5;
        @(negedge clk);
        wr = 1'b0;
        d0 = done_cnt;
        cs_down();
        xfer(8'h3C, 8, 1'b0, mi);
        cs_up();
        check("single_miso", mi, 8'hA5);
        check("single_dout", dout, 8'h3C);
        check("single_model", m_dout, 8'h3C);
        check("single_rxv", 8'(rx_valid), 8'h01);
        check("single_done", 8'(done_cnt - d0), 8'h01);

        // Back-to-back in one window without acknowledge.
        pulse_rd();
        d0 = done_cnt;
        cs_down();
        xfer(8'h11, 8, 1'b0, mi);
        xfer(8'h22, 8, 1'b0, mi);
        cs_up();
        check("b2b_dout", dout, 8'h22);
        check("b2b_ovr", 8'(overrun), 8'h01);
        check("b2b_model_ovr", 8'(m_ovr), 8'h01);
        check("b2b_done", 8'(done_cnt - d0), 8'h02);
        pulse_rd();
        check("ack_rxv", 8'(rx_valid), 8'h00);
        check("ack_ovr", 8'(overrun), 8'h00);

        // Abort after 5 bits, then a full word.
        d0 = done_cnt;
        cs_down();
        xfer(8'($urandom), 5, 1'b0, mi);
        cs_up();
        check("abort_done", 8'(done_cnt - d0), 8'h00);
        check("abort_rxv", 8'(rx_valid), 8'h00);
        check("abort_dout", dout, 8'h22);
        cs_down();
        xfer(8'hFF, 8, 1'b0, mi);
        cs_up();
        check("after_abort", dout, 8'hFF);

        // Acknowledge in the completion cycle of a new word.
        cs_down();
        xfer(8'h5A, 8, 1'b1, mi);
        cs_up();
        check("rdc_dout", dout, 8'h5A);
        check("rdc_rxv", 8'(rx_valid), 8'h01);
        check("rdc_ovr", 8'(overrun), 8'h00);

        // Reset mid-word; cs stays low through release.
        cs_down();
        xfer(8'hC3, 3, 1'b0, mi);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_flags", {3'h0, miso, done, rx_valid, busy, overrun}, 8'h00);
        d0 = done_cnt;
        wait_phase();
        xfer(8'h99, 8, 1'b0, mi);
        wait_phase();
        check("held_cs_done", 8'(done_cnt - d0), 8'h00);
        check("held_cs_busy", 8'(busy), 8'h00);
        cs_up();
        cs_down();
        xfer(8'h96, 8, 1'b0, mi);
        cs_up();
        check("retoggle_dout", dout, 8'h96);
        check("retoggle_done", 8'(done_cnt - d0), 8'h01);

        // Randomized windows with random local traffic.
        rand_local = 1'b1;
        for (int w = 0; w < 40; w++) begin
            cs_down();
            for (int k = 0; k < $urandom_range(1, 3); k++) begin
                if ($urandom_range(0, 5) == 0) begin
                    xfer(8'($urandom), $urandom_range(1, 7), 1'b0, mi);
                    break;
                end
                xfer(8'($urandom), 8, 1'b0, mi);
            end
            cs_up();
        end
        rand_local = 1'b0;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
